ecc_multilane_dec: RTL and testbench

- Multi-lane, pipelined SECDED (extended Hamming) decoder for the DDR3 read-data path.
- Decodes LANES independent codewords per beat and corrects single-bit errors in each lane. Flags double-bit errors per lane.
- Keeps saturating error counters and a first-error log for the scrub/diagnostic logic.
- Adds valid/ready flow control so it can sit between the PHY read FIFO and the controller read-return path.

---
 rtl/ecc_pkg.sv | 52 +++++
 rtl/ecc_dec.sv | 61 ++++++
 rtl/ecc_multilane_dec.sv | 188 ++++++++++++++++++
 tb/tb_ecc_multilane_dec.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the SECDED (extended Hamming) encoder/decoder.
//   calculate_m : number of Hamming check bits for K information bits.
//   cw_width    : full codeword width N = K + M + 1 (includes extended parity).
//   cw_hpos     : Hamming position held by a codeword bit (0 = extended parity).
//   cw_idx      : inverse of cw_hpos for positions 1..N-1.
//   data_hpos   : Hamming position of the j-th information bit.
// Codeword layout: Hamming positions 1..N-1 carry check bits at powers of two and
// information bits (in ascending order) everywhere else. The extended parity bit
// sits at bit N-1 when P0_LSB=0, or at bit 0 when P0_LSB=1.
package ecc_pkg;

    function automatic int calculate_m(input int k);
        for (int m = 1; m < 32; m++) begin
            if ((1 << m) >= (m + k + 1)) return m;
        end
        return 32;
    endfunction

    function automatic int cw_width(input int k);
        return k + calculate_m(k) + 1;
    endfunction

    function automatic int cw_hpos(input int idx, input int n, input bit p0_lsb);
        if (p0_lsb) return idx;
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

    function automatic int cw_idx(input int hpos, input bit p0_lsb);
        return p0_lsb ? hpos : hpos - 1;
    endfunction

    function automatic int data_hpos(input int j);
        int cnt;
        cnt = 0;
        for (int h = 3; h < 4 * j + 8; h++) begin
            if ((h & (h - 1)) != 0) begin
                if (cnt == j) return h;
                cnt++;
            end
        end
        return 0;
    endfunction

    // Types for the default DDR3 configuration (64 information bits per lane).
    localparam int ECC_K = 64;
    localparam int ECC_M = calculate_m(ECC_K);
    localparam int ECC_N = cw_width(ECC_K);

    typedef logic [ECC_M:0]   ecc_syndrome_t;  // {overall parity, Hamming syndrome}
    typedef logic [ECC_N-1:0] ecc_codeword_t;

endpackage

// File: rtl/ecc_dec.sv
// ecc_dec: combinational SECDED decoder for one codeword.
//   cw_i       in  N    received codeword
//   data_o     out K    corrected information bits
//   sb_o       out 1    single-bit error found and corrected
//   db_o       out 1    uncorrectable (double-bit) error
//   syndrome_o out M+1  {overall parity, Hamming syndrome}
module ecc_dec
    import ecc_pkg::*;
#(
    parameter int K      = 64,
    parameter int P0_LSB = 0,
    localparam int M     = calculate_m(K),
    localparam int N     = K + M + 1
) (
    input  logic [N-1:0] cw_i,
    output logic [K-1:0] data_o,
    output logic         sb_o,
    output logic         db_o,
    output logic [M:0]   syndrome_o
);

    // Codeword bits whose Hamming position has bit b set feed syndrome bit b.
    function automatic logic [N-1:0] syn_mask(input int b);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            if (((cw_hpos(i, N, P0_LSB != 0) >> b) & 1) != 0) m[i] = 1'b1;
        end
        return m;
    endfunction

    logic [M-1:0] syn;
    logic         par;
    logic         in_range;
    logic [N-1:0] cw_fix;

    for (genvar b = 0; b < M; b++) begin : g_syn
        localparam logic [N-1:0] MASK = syn_mask(b);
        assign syn[b] = ^(cw_i & MASK);
    end

    assign par      = ^cw_i;
    // A syndrome beyond the last position cannot come from a single flip.
    assign in_range = (syn <= M'(N - 1));

    // With odd overall parity the syndrome names the flipped position; 0 names
    // the extended parity bit itself.
    for (genvar i = 0; i < N; i++) begin : g_fix
        localparam int HP = cw_hpos(i, N, P0_LSB != 0);
        assign cw_fix[i] = cw_i[i] ^ (par && (syn == M'(HP)));
    end

    for (genvar j = 0; j < K; j++) begin : g_data
        assign data_o[j] = cw_fix[cw_idx(data_hpos(j), P0_LSB != 0)];
    end

    assign sb_o       = par && in_range;
    assign db_o       = (!par && (syn != '0)) || (par && !in_range);
    assign syndrome_o = {par, syn};

endmodule

// File: rtl/ecc_multilane_dec.sv
// ecc_multilane_dec: LANES-wide, two-stage pipelined SECDED decoder with
// valid/ready flow control, saturating error counters and a first-error log.
//   clk_i, rst_i (sync, active-high)
//   in_valid_i/in_ready_o/in_data_i     input beat, lane i at [i*N +: N]
//   out_valid_o/out_ready_i/out_data_o  output beat, lane i at [i*K +: K]
//   out_sb_o/out_db_o                   per-lane corrected / uncorrectable flags
//   sb_cnt_o/db_cnt_o                   saturating lane-event counters
//   log_valid_o/log_lane_o/log_syndrome_o/log_db_o  first-error log
//   clr_i                               clears counters and log (not the pipeline)
// Handshake: a beat moves when valid && ready on the same rising edge; a stage
// loads only when it is empty or its contents move on in that same edge, so the
// output payload stays stable while out_valid_o && !out_ready_i.
module ecc_multilane_dec
    import ecc_pkg::*;
#(
    parameter int K      = 64,
    parameter int LANES  = 4,
    parameter int P0_LSB = 0,
    parameter int CNT_W  = 16,
    localparam int M     = calculate_m(K),
    localparam int N     = K + M + 1,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [LANES*N-1:0]   in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [LANES*K-1:0]   out_data_o,
    output logic [LANES-1:0]     out_sb_o,
    output logic [LANES-1:0]     out_db_o,
    output logic [CNT_W-1:0]     sb_cnt_o,
    output logic [CNT_W-1:0]     db_cnt_o,
    output logic                 log_valid_o,
    output logic [LW-1:0]        log_lane_o,
    output logic [M:0]           log_syndrome_o,
    output logic                 log_db_o,
    input  logic                 clr_i
);

    // Wide enough that one beat's worth of events cannot overflow before saturation.
    localparam int SW = CNT_W + $clog2(LANES + 1);

    function automatic logic [SW-1:0] popcount(input logic [LANES-1:0] v);
        logic [SW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) c = c + SW'(v[i]);
        return c;
    endfunction

    logic                     adv1, adv2, hs;
    logic                     s1_valid_q;
    logic [LANES*N-1:0]       s1_data_q;
    logic [LANES*K-1:0]       dec_data;
    logic [LANES-1:0]         dec_sb, dec_db;
    logic [LANES*(M+1)-1:0]   dec_syn;
    logic                     out_valid_q;
    logic [LANES*K-1:0]       out_data_q;
    logic [LANES-1:0]         out_sb_q, out_db_q;
    logic [LANES*(M+1)-1:0]   out_syn_q;

    logic [CNT_W-1:0]         sb_cnt_q, sb_cnt_d, db_cnt_q, db_cnt_d;
    logic                     log_valid_q, log_valid_d, log_db_q, log_db_d;
    logic [LW-1:0]            log_lane_q, log_lane_d;
    logic [M:0]               log_syn_q, log_syn_d;
    logic [SW-1:0]            sb_sum, db_sum;
    logic [CNT_W-1:0]         sb_sat, db_sat;
    logic [LW-1:0]            err_lane;
    logic [M:0]               err_syn;
    logic                     err_db;

    assign adv2       = !out_valid_q || out_ready_i;
    assign adv1       = !s1_valid_q || adv2;
    assign in_ready_o = adv1 && !rst_i;
    assign hs         = out_valid_q && out_ready_i;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ecc_dec #(.K(K), .P0_LSB(P0_LSB)) u_dec (
            .cw_i       (s1_data_q[i*N +: N]),
            .data_o     (dec_data[i*K +: K]),
            .sb_o       (dec_sb[i]),
            .db_o       (dec_db[i]),
            .syndrome_o (dec_syn[i*(M+1) +: M+1])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sb_q    <= '0;
            out_db_q    <= '0;
            out_syn_q   <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid_i;
                s1_data_q  <= in_data_i;
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                out_data_q  <= dec_data;
                out_sb_q    <= dec_sb;
                out_db_q    <= dec_db;
                out_syn_q   <= dec_syn;
            end
        end
    end

    // Scan from the top lane down so the lowest erroring lane wins.
    always_comb begin
        err_lane = '0;
        err_syn  = '0;
        err_db   = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (out_sb_q[i] || out_db_q[i]) begin
                err_lane = LW'(i);
                err_syn  = out_syn_q[i*(M+1) +: M+1];
                err_db   = out_db_q[i];
            end
        end
    end

    assign sb_sum = SW'(sb_cnt_q) + popcount(out_sb_q);
    assign db_sum = SW'(db_cnt_q) + popcount(out_db_q);
    assign sb_sat = (|sb_sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : sb_sum[CNT_W-1:0];
    assign db_sat = (|db_sum[SW-1:CNT_W]) ? {CNT_W{1'b1}} : db_sum[CNT_W-1:0];

    always_comb begin
        sb_cnt_d    = sb_cnt_q;
        db_cnt_d    = db_cnt_q;
        log_valid_d = log_valid_q;
        log_lane_d  = log_lane_q;
        log_syn_d   = log_syn_q;
        log_db_d    = log_db_q;
        if (clr_i) begin
            // Clear wins over a coincident handshake; that beat is not counted.
            sb_cnt_d    = '0;
            db_cnt_d    = '0;
            log_valid_d = 1'b0;
            log_lane_d  = '0;
            log_syn_d   = '0;
            log_db_d    = 1'b0;
        end else if (hs) begin
            sb_cnt_d = sb_sat;
            db_cnt_d = db_sat;
            if (!log_valid_q && (|(out_sb_q | out_db_q))) begin
                log_valid_d = 1'b1;
                log_lane_d  = err_lane;
                log_syn_d   = err_syn;
                log_db_d    = err_db;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_cnt_q    <= '0;
            db_cnt_q    <= '0;
            log_valid_q <= 1'b0;
            log_lane_q  <= '0;
            log_syn_q   <= '0;
            log_db_q    <= 1'b0;
        end else begin
            sb_cnt_q    <= sb_cnt_d;
            db_cnt_q    <= db_cnt_d;
            log_valid_q <= log_valid_d;
            log_lane_q  <= log_lane_d;
            log_syn_q   <= log_syn_d;
            log_db_q    <= log_db_d;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign out_sb_o       = out_sb_q;
    assign out_db_o       = out_db_q;
    assign sb_cnt_o       = sb_cnt_q;
    assign db_cnt_o       = db_cnt_q;
    assign log_valid_o    = log_valid_q;
    assign log_lane_o     = log_lane_q;
    assign log_syndrome_o = log_syn_q;
    assign log_db_o       = log_db_q;

endmodule

// File: tb/tb_ecc_multilane_dec.sv
// Bench for ecc_multilane_dec in the K=8, LANES=2, CNT_W=4 configuration.
// Expected-entry layout (exp_q): {syn1[4:0], syn0[4:0], db[1:0], sb[1:0], data[15:0]}.
module tb_ecc_multilane_dec;

    localparam int K = 8, LANES = 2, CNT_W = 4, M = 4, N = 13, LW = 1, W = 30;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk_i = 1'b0;
    logic                 rst_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, clr_i;
    logic [LANES*N-1:0]   in_data_i;
    logic [LANES*K-1:0]   out_data_o;
    logic [LANES-1:0]     out_sb_o, out_db_o;
    logic [CNT_W-1:0]     sb_cnt_o, db_cnt_o;
    logic                 log_valid_o, log_db_o;
    logic [LW-1:0]        log_lane_o;
    logic [M:0]           log_syndrome_o;

    always #5 clk_i = ~clk_i;

    ecc_multilane_dec #(.K(K), .LANES(LANES), .P0_LSB(0), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_sb_o(out_sb_o), .out_db_o(out_db_o),
        .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o), .log_valid_o(log_valid_o),
        .log_lane_o(log_lane_o), .log_syndrome_o(log_syndrome_o), .log_db_o(log_db_o),
        .clr_i(clr_i)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int           pass_cnt = 0, chk_cnt = 0, out_hs_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp;
    logic         mon_en = 1'b0, rand_bp = 1'b0;
    int           m_sb_cnt = 0, m_db_cnt = 0;
    logic         m_log_v = 1'b0, m_log_db = 1'b0;
    logic [LW-1:0] m_log_lane = '0;
    logic [M:0]   m_log_syn = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Check bits are chosen so that the XOR of all set positions is zero;
    // the extended parity bit makes the whole codeword even.
    function automatic logic [N-1:0] enc(input logic [K-1:0] d);
        logic [N-1:0] cw;
        int s, j;
        cw = '0; s = 0; j = 0;
        for (int h = 1; h < N; h++) begin
            if ((h & (h - 1)) != 0) begin
                cw[h-1] = d[j];
                if (d[j]) s = s ^ h;
                j++;
            end
        end
        for (int b = 0; b < M; b++) cw[(1 << b) - 1] = s[b];
        cw[N-1] = ^cw[N-2:0];
        return cw;
    endfunction

    // Outcome follows from the number of flipped bits; the syndrome is the XOR
    // of flipped Hamming positions, with parity = odd flip count.
    function automatic logic [W-1:0] model(input logic [K-1:0] d0, d1, input logic [N-1:0] m0, m1);
        logic [W-1:0] e;
        logic [N-1:0] m;
        int s, p;
        e = '0;
        e[7:0] = d0;
        e[15:8] = d1;
        for (int l = 0; l < 2; l++) begin
            m = (l == 0) ? m0 : m1;
            s = 0; p = 0;
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    p = p ^ 1;
                    if (i != N - 1) s = s ^ (i + 1);
                end
            end
            e[16+l] = ($countones(m) == 1);
            e[18+l] = ($countones(m) == 2);
            e[20+5*l +: 5] = {p[0], s[3:0]};
        end
        return e;
    endfunction

    function automatic logic [N-1:0] rand_mask(input int n);
        logic [N-1:0] m;
        m = '0;
        while ($countones(m) < n) m = m | (N'(1) << $urandom_range(0, N - 1));
        return m;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [W-1:0]  e_mon;
    logic [15:0]   dmask_mon;

    always @(negedge clk_i) begin
        if (mon_en) begin
            check("cnt_log", {sb_cnt_o, db_cnt_o, log_valid_o, log_lane_o, log_syndrome_o, log_db_o},
                  {4'(m_sb_cnt), 4'(m_db_cnt), m_log_v, m_log_lane, m_log_syn, m_log_db});
            if (rst_i) begin
                exp_q.delete();
                m_sb_cnt = 0; m_db_cnt = 0;
                m_log_v = 0; m_log_lane = '0; m_log_syn = '0; m_log_db = 0;
            end else begin
                if (out_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("stray_beat", out_valid_o, 0);
                    end else begin
                        e_mon = exp_q[0];
                        dmask_mon = '0;
                        for (int l = 0; l < LANES; l++)
                            if (!e_mon[18+l]) dmask_mon[8*l +: 8] = 8'hFF;
                        check(out_ready_i ? "beat" : "stall_hold",
                              {out_db_o, out_sb_o, out_data_o & dmask_mon},
                              {e_mon[19:16], e_mon[15:0] & dmask_mon});
                        if (out_ready_i) begin
                            void'(exp_q.pop_front());
                            out_hs_cnt++;
                            if (!clr_i) begin
                                m_sb_cnt = m_sb_cnt + $countones(e_mon[17:16]);
                                m_db_cnt = m_db_cnt + $countones(e_mon[19:18]);
                                if (m_sb_cnt > 15) m_sb_cnt = 15;
                                if (m_db_cnt > 15) m_db_cnt = 15;
                                if (!m_log_v && (e_mon[19:16] != 0)) begin
                                    for (int l = LANES - 1; l >= 0; l--) begin
                                        if (e_mon[16+l] || e_mon[18+l]) begin
                                            m_log_lane = LW'(l);
                                            m_log_syn  = e_mon[20+5*l +: 5];
                                            m_log_db   = e_mon[18+l];
                                        end
                                    end
                                    m_log_v = 1'b1;
                                end
                            end
                        end
                    end
                end
                if (clr_i) begin
                    m_sb_cnt = 0; m_db_cnt = 0;
                    m_log_v = 0; m_log_lane = '0; m_log_syn = '0; m_log_db = 0;
                end
                if (in_valid_i && in_ready_o) exp_q.push_back(cur_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic randomize_ctl();
        out_ready_i = ($urandom_range(0, 3) != 0);
        clr_i       = ($urandom_range(0, 30) == 0);
    endtask

    task automatic send(input logic [K-1:0] d0, d1, input logic [N-1:0] m0, m1);
        int waited;
        waited = 0;
        in_valid_i = 1'b1;
        in_data_i  = {enc(d1) ^ m1, enc(d0) ^ m0};
        cur_exp    = model(d0, d1, m0, m1);
        forever begin
            @(negedge clk_i);
            if (in_ready_o) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", in_ready_o, 1);
                break;
            end
            @(posedge clk_i); #1;
            if (rand_bp) randomize_ctl();
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        if (rand_bp) randomize_ctl();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk_i); #1; n++; end
        check("drain", exp_q.size(), 0);
        idle(1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0]  d0, d1;
        logic [12:0] m0, m1;
        logic [15:0] dmask, data;
        logic [1:0]  sb, db;
        logic [3:0]  sbc, dbc;
        logic        lv, ll, ldb;
        logic [4:0]  lsyn;
    } vec_t;

    vec_t vt[3];
    int   hs0;

    initial begin
        vt[0] = '{8'hA5, 8'hA5, 13'h0000, 13'h0000, 16'hFFFF, 16'hA5A5, 2'b00, 2'b00,
                  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'h00};
        vt[1] = '{8'hA5, 8'hA5, 13'h0000, 13'h0008, 16'hFFFF, 16'hA5A5, 2'b10, 2'b00,
                  4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 5'h14};
        vt[2] = '{8'hA5, 8'hA5, 13'h0021, 13'h1000, 16'hFF00, 16'hA5A5, 2'b10, 2'b01,
                  4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 5'h14};

        rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1; clr_i = 1'b0;
        cur_exp = '0;
        idle(3);
        @(negedge clk_i);
        check("rst_out", {out_valid_o, out_data_o, out_sb_o, out_db_o}, 0);
        check("rst_cnt_log", {sb_cnt_o, db_cnt_o, log_valid_o, log_lane_o, log_syndrome_o, log_db_o}, 0);
        check("rst_in_ready", in_ready_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        mon_en = 1'b1;

        // Vectors 1-3: clean beat, single flip, mixed double/single flip.
        for (int i = 0; i < 3; i++) begin
            send(vt[i].d0, vt[i].d1, vt[i].m0, vt[i].m1);
            @(negedge clk_i); check("latency_gap", out_valid_o, 0);
            @(negedge clk_i); check("latency_valid", out_valid_o, 1);
            check("vec_data", out_data_o & vt[i].dmask, vt[i].data & vt[i].dmask);
            check("vec_sb", out_sb_o, vt[i].sb);
            check("vec_db", out_db_o, vt[i].db);
            @(negedge clk_i);
            check("vec_cnt", {sb_cnt_o, db_cnt_o}, {vt[i].sbc, vt[i].dbc});
            check("vec_log", {log_valid_o, log_lane_o, log_syndrome_o, log_db_o},
                  {vt[i].lv, vt[i].ll, vt[i].lsyn, vt[i].ldb});
            @(posedge clk_i); #1;
        end

        // Backpressure: two beats fill the pipe, the third is refused until release.
        hs0 = out_hs_cnt;
        out_ready_i = 1'b0;
        send(8'h11, 8'h22, '0, '0);
        send(8'h33, 8'h44, '0, '0);
        in_valid_i = 1'b1;
        in_data_i  = {enc(8'h66), enc(8'h55)};
        cur_exp    = model(8'h55, 8'h66, '0, '0);
        repeat (4) begin
            @(negedge clk_i); check("bp_in_ready", in_ready_o, 0);
            @(posedge clk_i); #1;
        end
        out_ready_i = 1'b1;
        send(8'h55, 8'h66, '0, '0);
        send(8'h77, 8'h88, '0, '0);
        drain();
        check("bp_beat_count", out_hs_cnt - hs0, 4);

        // Saturation of the single-bit counter.
        for (int i = 0; i < 10; i++)
            send(8'($urandom), 8'($urandom), rand_mask(1), rand_mask(1));
        drain();
        check("sat_sb", sb_cnt_o, 4'hF);
        send(8'h5A, 8'hC3, rand_mask(1), rand_mask(1));
        drain();
        check("sat_sb_hold", sb_cnt_o, 4'hF);

        // Clear coinciding with an error handshake (log full, then log empty).
        for (int r = 0; r < 2; r++) begin
            send(8'h3C, 8'h96, rand_mask(1), rand_mask(2));
            @(posedge clk_i); #1;
            clr_i = 1'b1;
            @(negedge clk_i); check("clr_hs", out_valid_o && out_ready_i, 1);
            @(posedge clk_i); #1;
            clr_i = 1'b0;
            @(negedge clk_i);
            check("clr_result", {sb_cnt_o, db_cnt_o, log_valid_o}, 0);
            @(posedge clk_i); #1;
        end

        // Reset with two beats in flight.
        out_ready_i = 1'b0;
        send(8'hE1, 8'h1E, '0, '0);
        send(8'hD2, 8'h2D, rand_mask(1), '0);
        rst_i = 1'b1;
        @(negedge clk_i); check("rst_mid_in_ready", in_ready_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i); check("rst_mid_flush", out_valid_o, 0);
        idle(6);
        @(negedge clk_i); check("rst_no_stale", out_valid_o, 0);
        @(posedge clk_i); #1;

        // Randomized traffic with backpressure and occasional clears.
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++)
            send(8'($urandom), 8'($urandom),
                 rand_mask($urandom_range(0, 2)), rand_mask($urandom_range(0, 2)));
        rand_bp = 1'b0;
        out_ready_i = 1'b1;
        clr_i = 1'b0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
